// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// returns {remainder, quotient} with a registered ready flag held until start drops.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

   state_t             state;
   logic [CNT_W-1:0]   counter;
   logic [WIDTH-1:0]   divisor;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic               neg_a;
   logic               neg_b;
   logic               is_signed;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     trial;

   // Magnitude of an operand; the most negative value maps onto itself, which is
   // still correct when the register is then treated as unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   // Partial remainder gains one bit of headroom so the trial difference sign is exact.
   always_comb begin
      shifted = {rem, quo[WIDTH-1]};
      trial   = shifted - {1'b0, divisor};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ready_o  <= 1'b0;
         result_o <= '0;
         counter  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= BYZERO;
                  end else begin
                     state     <= ON;
                     divisor   <= mag(opdata2_i, signed_div_i);
                     quo       <= mag(opdata1_i, signed_div_i);
                     rem       <= '0;
                     counter   <= '0;
                     neg_a     <= opdata1_i[WIDTH-1];
                     neg_b     <= opdata2_i[WIDTH-1];
                     is_signed <= signed_div_i;
                  end
               end
            end
            BYZERO: begin
               if (annul_i) begin
                  state <= IDLE;
               end else begin
                  state    <= END;
                  result_o <= '0;
                  ready_o  <= 1'b1;
               end
            end
            ON: begin
               if (annul_i) begin
                  state    <= IDLE;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end else if (counter == CNT_W'(WIDTH)) begin
                  state    <= END;
                  ready_o  <= 1'b1;
                  result_o <= {fix_sign(rem, is_signed && neg_a),
                               fix_sign(quo, is_signed && (neg_a ^ neg_b))};
               end else begin
                  if (!trial[WIDTH]) begin
                     rem <= trial[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b1};
                  end else begin
                     rem <= shifted[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b0};
                  end
                  counter <= counter + 1'b1;
               end
            end
            END: begin
               if (!start_i) begin
                  state    <= IDLE;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
